// File: rtl/spi_cmd_seq_pkg.sv
// Shared types and constants for the SPI command sequencer.
// Opcode constants cover the common serial-flash commands used by the control logic.
package spi_cmd_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_OP,
      ST_ADDR,
      ST_DATA,
      ST_DRAIN,
      ST_GAP
   } state_e;

   localparam int unsigned ADDR_BYTES = 3;
   localparam logic [7:0]  FILL_BYTE  = 8'hFF;

   localparam logic [7:0]  OP_READ = 8'h03;
   localparam logic [7:0]  OP_PP   = 8'h02;
   localparam logic [7:0]  OP_WREN = 8'h06;
   localparam logic [7:0]  OP_RDSR = 8'h05;
   localparam logic [7:0]  OP_RDID = 8'h9F;

   // Byte position 1..3 after the opcode selects the address byte, MSB first.
   function automatic logic [7:0] addr_byte(input logic [23:0] addr, input logic [1:0] pos);
      logic [7:0] b;
      case (pos)
         2'd1:    b = addr[23:16];
         2'd2:    b = addr[15:8];
         default: b = addr[7:0];
      endcase
      return b;
   endfunction

endpackage

// File: rtl/spi_cmd_seq_if.sv
// Host command/data and SPI byte-driver signals of the command sequencer.
// Optional cmd_dummy exists only when SPI_CMD_SEQ_DUMMY_EN is defined.
interface spi_cmd_seq_if #(
   parameter int unsigned LEN_W = 8
);
   logic             cmd_valid;
   logic             cmd_ready;
   logic [7:0]       cmd_op;
   logic             cmd_addr_en;
   logic [23:0]      cmd_addr;
   logic             cmd_dir;
   logic [LEN_W-1:0] cmd_len;
`ifdef SPI_CMD_SEQ_DUMMY_EN
   logic             cmd_dummy;
`endif
   logic [7:0]       wr_data;
   logic             wr_valid;
   logic             wr_ready;
   logic [7:0]       rd_data;
   logic             rd_valid;
   logic             busy;
   logic             done;
   logic             err_underrun;
   logic             spi_start;
   logic             spi_end;
   logic [7:0]       data_send;
   logic             send_done;
   logic             rec_done;
   logic [7:0]       data_rec;

   modport master (
`ifdef SPI_CMD_SEQ_DUMMY_EN
      output cmd_dummy,
`endif
      output cmd_valid, cmd_op, cmd_addr_en, cmd_addr, cmd_dir, cmd_len,
             wr_data, wr_valid, send_done, rec_done, data_rec,
      input  cmd_ready, wr_ready, rd_data, rd_valid, busy, done, err_underrun,
             spi_start, spi_end, data_send
   );

   modport slave (
`ifdef SPI_CMD_SEQ_DUMMY_EN
      input  cmd_dummy,
`endif
      input  cmd_valid, cmd_op, cmd_addr_en, cmd_addr, cmd_dir, cmd_len,
             wr_data, wr_valid, send_done, rec_done, data_rec,
      output cmd_ready, wr_ready, rd_data, rd_valid, busy, done, err_underrun,
             spi_start, spi_end, data_send
   );

endinterface

// File: rtl/spi_cmd_seq.sv
// Command sequencer: one host command -> opcode, optional address/dummy, data bytes for the SPI byte driver.
// Optional fast-read dummy byte enabled by SPI_CMD_SEQ_DUMMY_EN.
module spi_cmd_seq
   import spi_cmd_seq_pkg::*;
#(
   parameter int unsigned LEN_W  = 8,
   parameter int unsigned CS_GAP = 4
) (
   input  logic         clk_1MHZ,
   input  logic         sys_rst_n,
   spi_cmd_seq_if.slave bus
);

   localparam int unsigned CW = LEN_W + 3;
   localparam int unsigned GW = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;

   state_e           state_q, state_d;
   logic [7:0]       op_q, op_d;
   logic             addr_en_q, addr_en_d;
   logic [23:0]      addr_q, addr_d;
   logic             dir_q, dir_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [CW-1:0]    sent_q, sent_d;
   logic [CW-1:0]    rec_q, rec_d;
   logic [GW-1:0]    gap_q, gap_d;
   logic [7:0]       pf_data_q, pf_data_d;
   logic             pf_valid_q, pf_valid_d;
   logic [LEN_W-1:0] fetch_left_q, fetch_left_d;
   logic [7:0]       data_send_q, data_send_d;
   logic [7:0]       rd_data_q, rd_data_d;
   logic             rd_valid_q, rd_valid_d;
   logic             spi_start_q, spi_start_d;
   logic             spi_end_q, spi_end_d;
   logic             done_q, done_d;
   logic             err_q, err_d;

   logic             hdr_dummy;
   logic [CW-1:0]    hdr_len;
   logic [CW-1:0]    tot_len;
   logic [CW-1:0]    nxt_idx;
   logic             in_xfer;
   logic             wr_take;

`ifdef SPI_CMD_SEQ_DUMMY_EN
   logic             dummy_q, dummy_d;
   assign hdr_dummy = dummy_q;
`else
   assign hdr_dummy = 1'b0;
`endif

   always_ff @(posedge clk_1MHZ or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q      <= ST_IDLE;
         op_q         <= '0;
         addr_en_q    <= 1'b0;
         addr_q       <= '0;
         dir_q        <= 1'b0;
         len_q        <= '0;
         sent_q       <= '0;
         rec_q        <= '0;
         gap_q        <= '0;
         pf_data_q    <= '0;
         pf_valid_q   <= 1'b0;
         fetch_left_q <= '0;
         data_send_q  <= '0;
         rd_data_q    <= '0;
         rd_valid_q   <= 1'b0;
         spi_start_q  <= 1'b0;
         spi_end_q    <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
`ifdef SPI_CMD_SEQ_DUMMY_EN
         dummy_q      <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         op_q         <= op_d;
         addr_en_q    <= addr_en_d;
         addr_q       <= addr_d;
         dir_q        <= dir_d;
         len_q        <= len_d;
         sent_q       <= sent_d;
         rec_q        <= rec_d;
         gap_q        <= gap_d;
         pf_data_q    <= pf_data_d;
         pf_valid_q   <= pf_valid_d;
         fetch_left_q <= fetch_left_d;
         data_send_q  <= data_send_d;
         rd_data_q    <= rd_data_d;
         rd_valid_q   <= rd_valid_d;
         spi_start_q  <= spi_start_d;
         spi_end_q    <= spi_end_d;
         done_q       <= done_d;
         err_q        <= err_d;
`ifdef SPI_CMD_SEQ_DUMMY_EN
         dummy_q      <= dummy_d;
`endif
      end
   end

   always_comb begin
      state_d      = state_q;
      op_d         = op_q;
      addr_en_d    = addr_en_q;
      addr_d       = addr_q;
      dir_d        = dir_q;
      len_d        = len_q;
      sent_d       = sent_q;
      rec_d        = rec_q;
      gap_d        = gap_q;
      pf_data_d    = pf_data_q;
      pf_valid_d   = pf_valid_q;
      fetch_left_d = fetch_left_q;
      data_send_d  = data_send_q;
      rd_data_d    = rd_data_q;
      rd_valid_d   = 1'b0;
      spi_start_d  = 1'b0;
      spi_end_d    = 1'b0;
      done_d       = 1'b0;
      err_d        = err_q;
`ifdef SPI_CMD_SEQ_DUMMY_EN
      dummy_d      = dummy_q;
`endif
      wr_take      = 1'b0;

      hdr_len = CW'(1) + (addr_en_q ? CW'(ADDR_BYTES) : '0) + CW'(hdr_dummy);
      tot_len = hdr_len + CW'(len_q);
      nxt_idx = sent_q + CW'(1);
      in_xfer = (state_q == ST_LOAD) || (state_q == ST_OP) ||
                (state_q == ST_ADDR) || (state_q == ST_DATA);

      // Prefetch is held off on send_done cycles so a byte is never captured and skipped together.
      if (in_xfer && dir_q && (fetch_left_q != '0) && !pf_valid_q &&
          !bus.send_done && bus.wr_valid) begin
         wr_take      = 1'b1;
         pf_data_d    = bus.wr_data;
         pf_valid_d   = 1'b1;
         fetch_left_d = fetch_left_q - LEN_W'(1);
      end

      if (((state_q == ST_OP) || (state_q == ST_ADDR) || (state_q == ST_DATA) ||
           (state_q == ST_DRAIN)) && bus.rec_done) begin
         rec_d = rec_q + CW'(1);
         if (!dir_q && (rec_q >= hdr_len)) begin
            rd_data_d  = bus.data_rec;
            rd_valid_d = 1'b1;
         end
      end

      case (state_q)
         ST_IDLE: begin
            if (bus.cmd_valid) begin
               op_d         = bus.cmd_op;
               addr_en_d    = bus.cmd_addr_en;
               addr_d       = bus.cmd_addr;
               dir_d        = bus.cmd_dir;
               len_d        = bus.cmd_len;
`ifdef SPI_CMD_SEQ_DUMMY_EN
               dummy_d      = bus.cmd_dummy;
`endif
               err_d        = 1'b0;
               sent_d       = '0;
               rec_d        = '0;
               gap_d        = '0;
               pf_valid_d   = 1'b0;
               fetch_left_d = bus.cmd_dir ? bus.cmd_len : '0;
               state_d      = ST_LOAD;
            end
         end
         ST_LOAD: begin
            data_send_d = op_q;
            spi_start_d = 1'b1;
            state_d     = ST_OP;
         end
         ST_OP, ST_ADDR, ST_DATA: begin
            if (bus.send_done) begin
               sent_d = nxt_idx;
               if (nxt_idx == tot_len) begin
                  spi_end_d = 1'b1;
                  state_d   = ST_DRAIN;
               end else if (nxt_idx < hdr_len) begin
                  state_d     = ST_ADDR;
                  data_send_d = (addr_en_q && (nxt_idx <= CW'(ADDR_BYTES)))
                                ? addr_byte(addr_q, nxt_idx[1:0]) : FILL_BYTE;
               end else begin
                  state_d = ST_DATA;
                  if (!dir_q) begin
                     data_send_d = FILL_BYTE;
                  end else if (pf_valid_q) begin
                     data_send_d = pf_data_q;
                     pf_valid_d  = 1'b0;
                  end else begin
                     // Underrun: the slot is filled and its host byte is no longer owed.
                     data_send_d  = FILL_BYTE;
                     err_d        = 1'b1;
                     fetch_left_d = fetch_left_q - LEN_W'(1);
                  end
               end
            end
         end
         ST_DRAIN: begin
            if (rec_q == tot_len) begin
               gap_d   = '0;
               state_d = ST_GAP;
            end
         end
         ST_GAP: begin
            if (gap_q == GW'(CS_GAP - 1)) begin
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end else begin
               gap_d = gap_q + GW'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign bus.cmd_ready    = (state_q == ST_IDLE);
   assign bus.busy         = (state_q != ST_IDLE);
   assign bus.wr_ready     = wr_take;
   assign bus.rd_data      = rd_data_q;
   assign bus.rd_valid     = rd_valid_q;
   assign bus.done         = done_q;
   assign bus.err_underrun = err_q;
   assign bus.spi_start    = spi_start_q;
   assign bus.spi_end      = spi_end_q;
   assign bus.data_send    = data_send_q;

endmodule

// File: tb/tb_spi_cmd_seq.sv
// Directed bench for spi_cmd_seq with a byte-level SPI driver model and host write supplier.
// Dummy-byte scenario is built only when SPI_CMD_SEQ_DUMMY_EN is defined.
`timescale 1ns/1ps
module tb_spi_cmd_seq;
   import spi_cmd_seq_pkg::*;

   localparam int unsigned LEN_W     = 8;
   localparam int unsigned CS_GAP    = 4;
   localparam int unsigned BYTE_CLKS = 8;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   spi_cmd_seq_if #(.LEN_W(LEN_W)) bus();

   spi_cmd_seq #(.LEN_W(LEN_W), .CS_GAP(CS_GAP)) dut (
      .clk_1MHZ (clk),
      .sys_rst_n(rst_n),
      .bus      (bus)
   );

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int end_cnt, start_cnt, done_cnt, wr_cnt, last_rec_cyc, done_cyc;
   logic [7:0] miso [16];
   logic [7:0] tx_log [$];
   logic [7:0] rd_log [$];
   logic [7:0] wr_q [$];
   logic [7:0] exp_tx [$];
   logic [7:0] exp_rd [$];

   always @(posedge clk) cyc <= cyc + 1;

   // SPI byte driver model: logs each byte on data_send, returns miso[] per byte.
   initial begin : driver
      int   idx;
      logic run;
      bus.send_done = 1'b0;
      bus.rec_done  = 1'b0;
      bus.data_rec  = '0;
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1 && bus.spi_start === 1'b1) begin
            idx = 0;
            run = 1'b1;
            tx_log.push_back(bus.data_send);
            while (run) begin
               for (int i = 0; i < BYTE_CLKS; i++) begin
                  @(negedge clk);
                  if (rst_n !== 1'b1) run = 1'b0;
               end
               if (run) begin
                  bus.send_done = 1'b1;
                  bus.rec_done  = 1'b1;
                  bus.data_rec  = miso[idx % 16];
                  last_rec_cyc  = cyc;
                  @(negedge clk);
                  bus.send_done = 1'b0;
                  bus.rec_done  = 1'b0;
                  idx++;
                  if (rst_n !== 1'b1 || bus.spi_end === 1'b1 || idx >= 64) begin
                     run = 1'b0;
                  end else begin
                     for (int i = 0; i < 3; i++) begin
                        @(negedge clk);
                        if (rst_n !== 1'b1) run = 1'b0;
                     end
                     if (run) tx_log.push_back(bus.data_send);
                  end
               end
            end
            bus.send_done = 1'b0;
            bus.rec_done  = 1'b0;
         end
      end
   end

   initial begin : writer
      bus.wr_valid = 1'b0;
      bus.wr_data  = '0;
      forever begin
         @(negedge clk);
         if (wr_q.size() != 0) begin
            bus.wr_valid = 1'b1;
            bus.wr_data  = wr_q[0];
         end else begin
            bus.wr_valid = 1'b0;
         end
         #4;
         if (bus.wr_valid === 1'b1 && bus.wr_ready === 1'b1) begin
            void'(wr_q.pop_front());
            wr_cnt++;
         end
      end
   end

   initial begin : monitor
      forever begin
         @(negedge clk);
         if (bus.rd_valid === 1'b1)  rd_log.push_back(bus.rd_data);
         if (bus.spi_end === 1'b1)   end_cnt++;
         if (bus.spi_start === 1'b1) start_cnt++;
         if (bus.done === 1'b1)      done_cnt++;
      end
   end

   initial begin : watchdog
      #5_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "bench timeout");
   end

   task automatic issue_cmd(input logic [7:0] op, input logic aen, input logic [23:0] addr,
                            input logic dir, input logic [7:0] len, input logic dmy);
      tx_log.delete();
      rd_log.delete();
      end_cnt = 0; start_cnt = 0; done_cnt = 0; wr_cnt = 0;
      @(negedge clk);
      bus.cmd_op      = op;
      bus.cmd_addr_en = aen;
      bus.cmd_addr    = addr;
      bus.cmd_dir     = dir;
      bus.cmd_len     = len;
`ifdef SPI_CMD_SEQ_DUMMY_EN
      bus.cmd_dummy   = dmy;
`else
      if (dmy) $display("note: dummy request ignored in this build");
`endif
      bus.cmd_valid   = 1'b1;
      @(negedge clk);
      bus.cmd_valid   = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int n;
      n = 0;
      while (bus.done !== 1'b1 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      done_cyc = cyc;
      checks++;
      if (bus.done !== 1'b1) begin
         failures++;
         $display("FAIL %s_done_timeout got=0 exp=1", name);
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_addr_en = 1'b0;
      bus.cmd_addr = '0; bus.cmd_dir = 1'b0; bus.cmd_len = '0;
`ifdef SPI_CMD_SEQ_DUMMY_EN
      bus.cmd_dummy = 1'b0;
`endif
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++; if (bus.cmd_ready !== 1'b1) begin failures++; $display("FAIL rst_cmd_ready got=%b exp=1", bus.cmd_ready); end
      checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", bus.busy); end
      checks++; if (bus.data_send !== 8'h00) begin failures++; $display("FAIL rst_data_send got=%h exp=00", bus.data_send); end
      checks++; if (bus.rd_data !== 8'h00) begin failures++; $display("FAIL rst_rd_data got=%h exp=00", bus.rd_data); end
      checks++; if (bus.err_underrun !== 1'b0) begin failures++; $display("FAIL rst_err got=%b exp=0", bus.err_underrun); end
      checks++;
      if ({bus.rd_valid, bus.wr_ready, bus.spi_start, bus.spi_end, bus.done} !== 5'b0) begin
         failures++;
         $display("FAIL rst_pulses got=%b exp=00000",
                  {bus.rd_valid, bus.wr_ready, bus.spi_start, bus.spi_end, bus.done});
      end
   endtask

   task automatic test_rdid();
      miso[0] = 8'h11; miso[1] = 8'hEF; miso[2] = 8'h40; miso[3] = 8'h18;
      issue_cmd(OP_RDID, 1'b0, 24'h0, 1'b0, 8'd3, 1'b0);
      wait_done("rdid");
      exp_tx = '{8'h9F, 8'hFF, 8'hFF, 8'hFF};
      exp_rd = '{8'hEF, 8'h40, 8'h18};
      checks++; if (tx_log.size() != exp_tx.size()) begin failures++; $display("FAIL rdid_tx_len got=%0d exp=%0d", tx_log.size(), exp_tx.size()); end
      for (int i = 0; i < exp_tx.size() && i < tx_log.size(); i++) begin
         checks++; if (tx_log[i] !== exp_tx[i]) begin failures++; $display("FAIL rdid_tx[%0d] got=%h exp=%h", i, tx_log[i], exp_tx[i]); end
      end
      checks++; if (rd_log.size() != exp_rd.size()) begin failures++; $display("FAIL rdid_rd_len got=%0d exp=%0d", rd_log.size(), exp_rd.size()); end
      for (int i = 0; i < exp_rd.size() && i < rd_log.size(); i++) begin
         checks++; if (rd_log[i] !== exp_rd[i]) begin failures++; $display("FAIL rdid_rd[%0d] got=%h exp=%h", i, rd_log[i], exp_rd[i]); end
      end
      checks++; if (end_cnt != 1) begin failures++; $display("FAIL rdid_spi_end got=%0d exp=1", end_cnt); end
      checks++; if (done_cnt != 1) begin failures++; $display("FAIL rdid_done got=%0d exp=1", done_cnt); end
      checks++; if (wr_cnt != 0) begin failures++; $display("FAIL rdid_wr_ready got=%0d exp=0", wr_cnt); end
      checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rdid_busy_after got=%b exp=0", bus.busy); end
   endtask

   task automatic test_pp();
      wr_q = '{8'hA5, 8'h5A};
      issue_cmd(OP_PP, 1'b1, 24'h001234, 1'b1, 8'd2, 1'b0);
      wait_done("pp");
      exp_tx = '{8'h02, 8'h00, 8'h12, 8'h34, 8'hA5, 8'h5A};
      checks++; if (tx_log.size() != exp_tx.size()) begin failures++; $display("FAIL pp_tx_len got=%0d exp=%0d", tx_log.size(), exp_tx.size()); end
      for (int i = 0; i < exp_tx.size() && i < tx_log.size(); i++) begin
         checks++; if (tx_log[i] !== exp_tx[i]) begin failures++; $display("FAIL pp_tx[%0d] got=%h exp=%h", i, tx_log[i], exp_tx[i]); end
      end
      checks++; if (wr_cnt != 2) begin failures++; $display("FAIL pp_wr_ready got=%0d exp=2", wr_cnt); end
      checks++; if (rd_log.size() != 0) begin failures++; $display("FAIL pp_rd_valid got=%0d exp=0", rd_log.size()); end
      checks++; if (bus.err_underrun !== 1'b0) begin failures++; $display("FAIL pp_err got=%b exp=0", bus.err_underrun); end
      checks++; if (end_cnt != 1) begin failures++; $display("FAIL pp_spi_end got=%0d exp=1", end_cnt); end
   endtask

   task automatic test_underrun();
      wr_q = '{8'hA5};
      issue_cmd(OP_PP, 1'b1, 24'h001234, 1'b1, 8'd2, 1'b0);
      wait_done("underrun");
      exp_tx = '{8'h02, 8'h00, 8'h12, 8'h34, 8'hA5, 8'hFF};
      checks++; if (tx_log.size() != exp_tx.size()) begin failures++; $display("FAIL ur_tx_len got=%0d exp=%0d", tx_log.size(), exp_tx.size()); end
      for (int i = 0; i < exp_tx.size() && i < tx_log.size(); i++) begin
         checks++; if (tx_log[i] !== exp_tx[i]) begin failures++; $display("FAIL ur_tx[%0d] got=%h exp=%h", i, tx_log[i], exp_tx[i]); end
      end
      checks++; if (wr_cnt != 1) begin failures++; $display("FAIL ur_wr_ready got=%0d exp=1", wr_cnt); end
      repeat (10) @(negedge clk);
      checks++; if (bus.err_underrun !== 1'b1) begin failures++; $display("FAIL ur_err_sticky got=%b exp=1", bus.err_underrun); end
   endtask

   task automatic test_wren();
      issue_cmd(OP_WREN, 1'b0, 24'h0, 1'b0, 8'd0, 1'b0);
      checks++; if (bus.err_underrun !== 1'b0) begin failures++; $display("FAIL wren_err_cleared got=%b exp=0", bus.err_underrun); end
      wait_done("wren");
      checks++; if (tx_log.size() != 1) begin failures++; $display("FAIL wren_tx_len got=%0d exp=1", tx_log.size()); end
      if (tx_log.size() > 0) begin
         checks++; if (tx_log[0] !== 8'h06) begin failures++; $display("FAIL wren_tx0 got=%h exp=06", tx_log[0]); end
      end
      checks++; if (end_cnt != 1) begin failures++; $display("FAIL wren_spi_end got=%0d exp=1", end_cnt); end
      checks++; if (wr_cnt != 0) begin failures++; $display("FAIL wren_wr_ready got=%0d exp=0", wr_cnt); end
      checks++; if (rd_log.size() != 0) begin failures++; $display("FAIL wren_rd_valid got=%0d exp=0", rd_log.size()); end
      checks++;
      if (done_cyc - last_rec_cyc != int'(CS_GAP) + 2) begin
         failures++;
         $display("FAIL wren_gap_latency got=%0d exp=%0d", done_cyc - last_rec_cyc, CS_GAP + 2);
      end
   endtask

   task automatic test_busy();
      miso[4] = 8'h77;
      issue_cmd(OP_READ, 1'b1, 24'hABCDEF, 1'b0, 8'd1, 1'b0);
      repeat (5) @(negedge clk);
      checks++; if (bus.cmd_ready !== 1'b0) begin failures++; $display("FAIL busy_cmd_ready got=%b exp=0", bus.cmd_ready); end
      checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL busy_busy got=%b exp=1", bus.busy); end
      bus.cmd_op = OP_WREN; bus.cmd_addr_en = 1'b0; bus.cmd_len = 8'd0;
      bus.cmd_valid = 1'b1;
      repeat (20) @(negedge clk);
      bus.cmd_valid = 1'b0;
      wait_done("busy");
      exp_tx = '{8'h03, 8'hAB, 8'hCD, 8'hEF, 8'hFF};
      checks++; if (tx_log.size() != exp_tx.size()) begin failures++; $display("FAIL busy_tx_len got=%0d exp=%0d", tx_log.size(), exp_tx.size()); end
      for (int i = 0; i < exp_tx.size() && i < tx_log.size(); i++) begin
         checks++; if (tx_log[i] !== exp_tx[i]) begin failures++; $display("FAIL busy_tx[%0d] got=%h exp=%h", i, tx_log[i], exp_tx[i]); end
      end
      checks++; if (rd_log.size() != 1) begin failures++; $display("FAIL busy_rd_len got=%0d exp=1", rd_log.size()); end
      if (rd_log.size() > 0) begin
         checks++; if (rd_log[0] !== 8'h77) begin failures++; $display("FAIL busy_rd0 got=%h exp=77", rd_log[0]); end
      end
      repeat (20) @(negedge clk);
      checks++; if (start_cnt != 1) begin failures++; $display("FAIL busy_ignored_cmd got=%0d exp=1", start_cnt); end
      checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL busy_idle_after got=%b exp=0", bus.busy); end
   endtask

   task automatic test_reset_mid();
      int n;
      miso[1] = 8'h21; miso[2] = 8'h32; miso[3] = 8'h43;
      miso[4] = 8'h54; miso[5] = 8'h65; miso[6] = 8'h76;
      issue_cmd(OP_RDSR, 1'b0, 24'h0, 1'b0, 8'd6, 1'b0);
      n = 0;
      while (rd_log.size() < 2 && n < 500) begin @(negedge clk); n++; end
      checks++; if (rd_log.size() < 2) begin failures++; $display("FAIL rmid_data_phase got=%0d exp=2", rd_log.size()); end
      rst_n = 1'b0;
      #1;
      checks++; if (bus.cmd_ready !== 1'b1) begin failures++; $display("FAIL rmid_cmd_ready got=%b exp=1", bus.cmd_ready); end
      checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rmid_busy got=%b exp=0", bus.busy); end
      checks++; if (bus.data_send !== 8'h00) begin failures++; $display("FAIL rmid_data_send got=%h exp=00", bus.data_send); end
      checks++; if (bus.rd_data !== 8'h00) begin failures++; $display("FAIL rmid_rd_data got=%h exp=00", bus.rd_data); end
      checks++;
      if ({bus.rd_valid, bus.spi_start, bus.spi_end, bus.done, bus.err_underrun} !== 5'b0) begin
         failures++;
         $display("FAIL rmid_pulses got=%b exp=00000",
                  {bus.rd_valid, bus.spi_start, bus.spi_end, bus.done, bus.err_underrun});
      end
      wr_q.delete();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      checks++; if (end_cnt != 0) begin failures++; $display("FAIL rmid_no_spi_end got=%0d exp=0", end_cnt); end
      checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rmid_idle got=%b exp=0", bus.busy); end
   endtask

`ifdef SPI_CMD_SEQ_DUMMY_EN
   task automatic test_dummy();
      miso[5] = 8'hC3;
      issue_cmd(8'h0B, 1'b1, 24'h000100, 1'b0, 8'd1, 1'b1);
      wait_done("dummy");
      exp_tx = '{8'h0B, 8'h00, 8'h01, 8'h00, 8'hFF, 8'hFF};
      checks++; if (tx_log.size() != exp_tx.size()) begin failures++; $display("FAIL dmy_tx_len got=%0d exp=%0d", tx_log.size(), exp_tx.size()); end
      for (int i = 0; i < exp_tx.size() && i < tx_log.size(); i++) begin
         checks++; if (tx_log[i] !== exp_tx[i]) begin failures++; $display("FAIL dmy_tx[%0d] got=%h exp=%h", i, tx_log[i], exp_tx[i]); end
      end
      checks++; if (rd_log.size() != 1) begin failures++; $display("FAIL dmy_rd_len got=%0d exp=1", rd_log.size()); end
      if (rd_log.size() > 0) begin
         checks++; if (rd_log[0] !== 8'hC3) begin failures++; $display("FAIL dmy_rd0 got=%h exp=C3", rd_log[0]); end
      end
   endtask
`endif

   initial begin : main
      for (int i = 0; i < 16; i++) miso[i] = 8'h00;
      test_reset();
      test_rdid();
      test_pp();
      test_underrun();
      test_wren();
      test_busy();
      test_reset_mid();
`ifdef SPI_CMD_SEQ_DUMMY_EN
      test_dummy();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/spi_cmd_seq.md
Name: spi_cmd_seq

Overview:
- Command sequencer directly upstream of the byte-level SPI master driver.
- Turns one host command into a byte stream: opcode, optional 24-bit address, N data bytes.
- Drives the driver's spi_start, spi_end and data_send; consumes send_done, rec_done and data_rec.
- Returns read-phase bytes to the host as a pulsed stream. Sits between the flash/peripheral control logic and the SPI driver.

Parameters:
LEN_W, 8, width of cmd_len; data phase length 0..2^LEN_W-1 bytes
CS_GAP, 4, minimum idle clk_1MHZ cycles after final rec_done before cmd_ready reasserts

Ports:
clk_1MHZ  in  1  block clock
sys_rst_n  in  1  reset
cmd_valid  in  1  command request
cmd_ready  out  1  command accepted when valid&ready
cmd_op  in  8  opcode byte
cmd_addr_en  in  1  send 3 address bytes, MSB first
cmd_addr  in  24  address
cmd_dir  in  1  0=read data phase, 1=write data phase
cmd_len  in  LEN_W  data phase byte count
wr_data  in  8  write byte
wr_valid  in  1  write byte available
wr_ready  out  1  write byte consumed (1-cycle pulse)
rd_data  out  8  read byte
rd_valid  out  1  rd_data valid (1-cycle pulse)
busy  out  1  command in progress
done  out  1  1-cycle pulse at end of command
err_underrun  out  1  sticky; cleared on next command accept
spi_start  out  1  to driver, 1-cycle pulse
spi_end  out  1  to driver, 1-cycle pulse
data_send  out  8  to driver, held stable for the whole byte
send_done  in  1  driver: current byte shifted out
rec_done  in  1  driver: data_rec holds a complete byte
data_rec  in  8  driver receive byte

Behaviour:
- Reset sys_rst_n is asynchronous, active-low. Clock is clk_1MHZ.
- Reset values:
  - All pulses = 0, busy = 0, err_underrun = 0.
  - data_send = 8'h00, rd_data = 8'h00.
  - cmd_ready = 1 in IDLE.
- Reset mid-command aborts immediately. No spi_end is issued; the driver is reset by the same reset.
- Total bytes T = 1 + 3*cmd_addr_en + cmd_len. All fields are latched on accept.
- FSM states: IDLE, LOAD, OP, ADDR, DATA, DRAIN, GAP.
- IDLE:
  - cmd_ready = 1.
  - On accept: latch fields, clear err_underrun, go to LOAD, busy = 1.
- LOAD:
  - data_send <= cmd_op, spi_start pulse, then go to OP.
  - If write with cmd_len > 0, prefetch: capture wr_data when wr_valid, pulse wr_ready.
- Byte advance on each send_done:
  - Load data_send with the next byte in sequence: addr[23:16], [15:8], [7:0], then data bytes.
  - Write data: use the prefetched byte, then prefetch the next one.
  - If no prefetched byte is available at send_done: data_send <= 8'hFF and err_underrun <= 1.
  - Read data: data_send <= 8'hFF.
  - send_done must update data_send in that same cycle. The driver samples the next bit 4 clocks later.
- spi_end:
  - Pulsed in the cycle after the send_done of byte T (the final byte), then go to DRAIN.
  - For T = 1 this is the first send_done.
  - Exactly one spi_end per command.
- rec_done handling:
  - A rec counter counts every rec_done.
  - The first 1 + 3*addr_en received bytes are discarded.
  - Subsequent bytes with cmd_dir = 0: rd_data <= data_rec, rd_valid pulse the same cycle as the register update (1 clk after rec_done).
  - cmd_dir = 1: received bytes are discarded.
- DRAIN: wait for rec counter == T, then go to GAP.
- GAP:
  - Count CS_GAP cycles.
  - Then pulse done, busy = 0, go to IDLE.
- Boundaries:
  - cmd_len = 0: no data phase and no wr_ready pulses.
  - cmd_valid while busy is ignored.
  - The byte counter is sized LEN_W+3 bits; no wrap for max T = 2^LEN_W+3.

Optional Feature:
- Macro SPI_CMD_SEQ_DUMMY_EN.
- When defined:
  - Adds input cmd_dummy (1 bit).
  - When set, one 8'hFF dummy byte is sent after the address (after the opcode if no address). It is counted in T.
  - The received byte for the dummy is discarded (fast-read support).
- When undefined: no port, no dummy byte, identical timing otherwise.

Decomposition:
- Package spi_cmd_seq_pkg:
  - FSM state enum.
  - ADDR_BYTES = 3.
  - FILL_BYTE = 8'hFF.
  - Opcode constants: OP_READ 8'h03, OP_PP 8'h02, OP_WREN 8'h06, OP_RDSR 8'h05, OP_RDID 8'h9F.
- Single module; no sub-module. The write prefetch register is inline.

Test Plan:
- RDID: cmd_op = 9F, addr_en = 0, dir = 0, len = 3; MISO model returns EF,40,18 → data_send 9F,FF,FF,FF; rd_valid ×3 with EF,40,18; one spi_end; done.
- PP: op = 02, addr = 001234, dir = 1, len = 2, wr bytes A5,5A → data_send 02,00,12,34,A5,5A; wr_ready ×2; no rd_valid; err_underrun = 0.
- Underrun: same as PP but only A5 supplied → 6th byte = FF; err_underrun = 1 until next accept.
- WREN: op = 06, len = 0, addr_en = 0 → single byte; spi_end cycle after first send_done; done after CS_GAP.
- Busy/reset: cmd_valid during transfer → cmd_ready = 0, command ignored. sys_rst_n low mid-DATA → all outputs return to reset values, IDLE.
- With SPI_CMD_SEQ_DUMMY_EN: op = 0B, addr = 000100, dummy = 1, len = 1 → 6 bytes sent; rd_valid once with the 6th received byte.
